// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - branch, instruction-memory and decode handshake bundle of the fetch unit
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            nextPCSource;
  logic [XLEN-1:0] branchTarget;
  logic            branchValid;
  logic            imemReqValid;
  logic            imemReqReady;
  logic [XLEN-1:0] imemAddr;
  logic            imemRespValid;
  logic [31:0]     imemRespData;
  logic            instValid;
  logic            instReady;
  logic [31:0]     instData;
  logic [XLEN-1:0] instPC;
  logic            fetchFault;

  modport master (
    input  nextPCSource, branchTarget, branchValid,
    input  imemReqReady, imemRespValid, imemRespData, instReady,
    output imemReqValid, imemAddr, instValid, instData, instPC, fetchFault
  );

  modport slave (
    output nextPCSource, branchTarget, branchValid,
    output imemReqReady, imemRespValid, imemRespData, instReady,
    input  imemReqValid, imemAddr, instValid, instData, instPC, fetchFault
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - multicycle PC/fetch FSM, one outstanding imem request
// Optional misaligned-target trap: define FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_fetch_unit_if.master fi
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] RESOLVE = 3'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] FAULT   = 3'd5;
`endif

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_pc;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] aligned_target;
  logic [XLEN-1:0] next_pc;

  assign aligned_target = {fi.branchTarget[XLEN-1:2], 2'b00};
  assign next_pc        = fi.nextPCSource ? aligned_target : pc + XLEN'(4);

  assign fi.imemReqValid = (state == REQ);
  assign fi.imemAddr     = pc;
  assign fi.instValid    = (state == HOLD);
  assign fi.instData     = inst_data;
  assign fi.instPC       = inst_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  logic misaligned_taken;

  assign misaligned_taken = fi.nextPCSource && (fi.branchTarget[1:0] != 2'b00);
  assign fi.fetchFault    = fault_q;
`else
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^fi.branchTarget[1:0];
  assign fi.fetchFault      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_pc   <= RESET_PC;
      inst_data <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (fi.imemReqReady) state <= WAIT;
        end
        // Responses are only sampled here, so stale data in other states is dropped.
        WAIT: begin
          if (fi.imemRespValid) begin
            inst_data <= fi.imemRespData;
            inst_pc   <= pc;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (fi.instReady) state <= RESOLVE;
        end
        RESOLVE: begin
          if (fi.branchValid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned_taken) begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              pc    <= next_pc;
              state <= REQ;
            end
`else
            pc    <= next_pc;
            state <= REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        FAULT: state <= FAULT;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit (honours FETCH_MISALIGN_TRAP_EN)
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_data;
  logic [31:0] stale;
  bit faulted = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fi   (bus.master)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("%s", tag);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.imemReqValid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(32'(bus.imemReqValid), 32'd1, "req_valid_seen");
  endtask

  // One complete fetch: request, response, decode handshake, branch resolution.
  task automatic do_fetch(input logic [31:0] word, input logic take, input logic [31:0] target,
                          input int rq_d, input int rs_d, input int hd_d, input int br_d);
    wait_req();
    chk(bus.imemAddr, exp_pc, "req_addr");
    for (int i = 0; i < rq_d; i++) begin
      bus.imemReqReady = 1'b0;
      @(negedge clk);
      chk(bus.imemAddr, exp_pc, "addr_stable");
      chk(32'(bus.imemReqValid), 32'd1, "req_held");
    end
    bus.imemReqReady = 1'b1;
    @(negedge clk);
    bus.imemReqReady = 1'b0;
    chk(32'(bus.imemReqValid), 32'd0, "single_accept");
    for (int i = 0; i < rs_d; i++) begin
      @(negedge clk);
      chk(32'(bus.instValid), 32'd0, "no_early_inst");
    end
    bus.imemRespValid = 1'b1;
    bus.imemRespData  = word;
    @(negedge clk);
    bus.imemRespValid = 1'b0;
    bus.imemRespData  = $urandom;
    chk(32'(bus.instValid), 32'd1, "inst_valid");
    chk(bus.instData, word, "inst_data");
    chk(bus.instPC, exp_pc, "inst_pc");
    for (int i = 0; i < hd_d; i++) begin
      bus.imemRespValid = 1'b1;
      bus.imemRespData  = $urandom;
      bus.branchValid   = 1'b1;
      bus.nextPCSource  = 1'($urandom);
      bus.branchTarget  = $urandom;
      @(negedge clk);
      chk(32'(bus.instValid), 32'd1, "hold_valid");
      chk(bus.instData, word, "hold_data");
      chk(bus.instPC, exp_pc, "hold_pc");
    end
    bus.imemRespValid = 1'b0;
    bus.instReady     = 1'b1;
    bus.branchValid   = 1'b1;
    bus.nextPCSource  = 1'b1;
    bus.branchTarget  = 32'h0000_1230;
    @(negedge clk);
    bus.instReady   = 1'b0;
    bus.branchValid = 1'b0;
    chk(32'(bus.instValid), 32'd0, "inst_drop");
    chk(32'(bus.imemReqValid), 32'd0, "no_req_resolve");
    for (int i = 0; i < br_d; i++) begin
      @(negedge clk);
      chk(32'(bus.imemReqValid), 32'd0, "resolve_wait");
    end
    bus.branchValid  = 1'b1;
    bus.nextPCSource = take;
    bus.branchTarget = target;
    @(negedge clk);
    bus.branchValid = 1'b0;
    if (TRAP_EN && take && target[1:0] != 2'b00) faulted = 1'b1;
    else if (take) exp_pc = target & 32'hFFFF_FFFC;
    else exp_pc = exp_pc + 32'd4;
    if (faulted) begin
      chk(32'(bus.fetchFault), 32'd1, "fault_set");
      chk(32'(bus.imemReqValid), 32'd0, "fault_no_req");
    end else begin
      chk(32'(bus.imemReqValid), 32'd1, "req_next");
      chk(bus.imemAddr, exp_pc, "next_addr");
    end
  endtask

  initial begin
    bus.nextPCSource = 1'b0; bus.branchTarget = '0; bus.branchValid = 1'b0;
    bus.imemReqReady = 1'b0; bus.imemRespValid = 1'b0; bus.imemRespData = '0;
    bus.instReady = 1'b0;
    repeat (2) @(negedge clk);
    chk(32'(bus.imemReqValid), 32'd0, "rst_req_valid");
    chk(bus.imemAddr, 32'h0, "rst_addr");
    chk(32'(bus.instValid), 32'd0, "rst_inst_valid");
    chk(bus.instData, 32'h0, "rst_inst_data");
    chk(bus.instPC, 32'h0, "rst_inst_pc");
    chk(32'(bus.fetchFault), 32'd0, "rst_fault");
    rst_n = 1'b1;

    do_fetch(32'h0050_0093, 1'b0, 32'h0, 0, 0, 0, 0);
    do_fetch(32'h1111_1111, 1'b0, 32'h0, 3, 0, 0, 0);
    do_fetch(32'h2222_2222, 1'b0, 32'h0, 0, 1, 5, 0);
    do_fetch(32'h3333_3333, 1'b0, 32'h0, 0, 0, 0, 2);
    do_fetch(32'h4444_4444, 1'b0, 32'h0, 0, 0, 0, 0);
    chk(exp_pc, 32'h14, "model_pc_after_nt");
    do_fetch(32'h5555_5555, 1'b1, 32'h40, 0, 0, 0, 0);
    do_fetch(32'h6666_6666, 1'b1, 32'hFFFF_FFFC, 1, 1, 1, 1);
    do_fetch(32'h7777_7777, 1'b0, 32'h0, 0, 0, 0, 0);
    chk(bus.imemAddr, 32'h0, "wrap_addr");

    for (int k = 0; k < 20; k++) begin
      do_fetch($urandom, 1'($urandom), $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while a response is outstanding.
    wait_req();
    bus.imemReqReady = 1'b1;
    @(negedge clk);
    bus.imemReqReady = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk(32'(bus.imemReqValid), 32'd0, "async_rst_req");
    chk(bus.imemAddr, 32'h0, "async_rst_addr");
    chk(bus.instData, 32'h0, "async_rst_data");
    chk(bus.instPC, 32'h0, "async_rst_pc");
    @(negedge clk);
    stale = $urandom;
    rst_n = 1'b1;
    bus.imemRespValid = 1'b1;
    bus.imemRespData  = stale;
    @(negedge clk);
    bus.imemRespValid = 1'b0;
    chk(32'(bus.instValid), 32'd0, "stale_resp_ignored");
    chk(bus.instData, 32'h0, "stale_data_ignored");
    exp_pc = 32'h0;
    exp_data = $urandom;
    do_fetch(exp_data, 1'b1, 32'h42, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 8; i++) begin
      bus.branchValid = 1'b1;
      bus.imemReqReady = 1'b1;
      @(negedge clk);
      chk(32'(bus.imemReqValid), 32'd0, "fault_sticky_req");
      chk(32'(bus.instValid), 32'd0, "fault_sticky_inst");
      chk(32'(bus.fetchFault), 32'd1, "fault_sticky");
    end
    bus.branchValid = 1'b0;
    bus.imemReqReady = 1'b0;
    rst_n = 1'b0;
    #1 chk(32'(bus.fetchFault), 32'd0, "fault_cleared");
    @(negedge clk);
    rst_n = 1'b1;
    faulted = 1'b0;
    exp_pc = 32'h0;
    do_fetch($urandom, 1'b0, 32'h0, 0, 0, 0, 0);
`else
    chk(bus.imemAddr, 32'h40, "misaligned_forced");
    do_fetch($urandom, 1'b0, 32'h0, 0, 0, 0, 0);
    chk(32'(bus.fetchFault), 32'd0, "no_fault");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
